// File: rtl/bitcalc_pkg.sv
// Shared encodings for the sequential bit-operation unit.
package bitcalc_pkg;

  typedef enum logic [2:0] {
    KIND_PASS = 3'b000,
    KIND_OR   = 3'b001,
    KIND_AND  = 3'b010,
    KIND_XOR  = 3'b011,
    KIND_NOT  = 3'b100,
    KIND_SHL  = 3'b101,
    KIND_SHR  = 3'b110,
    KIND_ROL  = 3'b111
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Shift-amount width; floor of 1 keeps the counter legal for tiny widths.
  function automatic int unsigned shamt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic logic is_shift(input kind_e k);
    return (k == KIND_SHL) || (k == KIND_SHR) || (k == KIND_ROL);
  endfunction

endpackage

// File: rtl/bitcalc_logic.sv
// Single-cycle PASS/OR/AND/XOR/NOT unit; shift kinds fall through to PASS.
module bitcalc_logic
  import bitcalc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  kind_e              kind,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    y = a;
    case (kind)
      KIND_OR:  y = a | b;
      KIND_AND: y = a & b;
      KIND_XOR: y = a ^ b;
      KIND_NOT: y = ~a;
      default:  y = a;
    endcase
  end

endmodule

// File: rtl/bitcalc_seq.sv
// Registered WIDTH-bit bit-operation unit with one-bit-per-cycle shifter
// and valid/ready handshakes on input and output.
module bitcalc_seq
  import bitcalc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] INPUT1,
  input  logic [WIDTH-1:0] INPUT2,
  input  logic [2:0]       KIND,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUTPUT,
  output logic             IS_ZERO,
  output logic             CARRY
);

  localparam int unsigned SW = shamt_width(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              carry_q, carry_d;
  logic [SW-1:0]     count_q, count_d;
  kind_e             op_q, op_d;

  kind_e             kind_in;
  logic [SW-1:0]     amount;
  logic [WIDTH-1:0]  logic_y;
  logic              in_ready;
  logic              accept;

  assign kind_in = kind_e'(KIND);
  assign amount  = INPUT2[SW-1:0];

  bitcalc_logic #(.WIDTH(WIDTH)) u_logic (
    .kind (kind_in),
    .a    (INPUT1),
    .b    (INPUT2),
    .y    (logic_y)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      op_q    <= KIND_PASS;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && OUT_READY);
  assign accept   = IN_VALID && in_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      ST_SHIFT: begin
        count_d = count_q - SW'(1);
        case (op_q)
          KIND_SHR: begin
            carry_d = out_q[0];
            out_d   = {1'b0, out_q[WIDTH-1:1]};
          end
          KIND_ROL: begin
            carry_d = out_q[WIDTH-1];
            out_d   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
          end
          default: begin
            carry_d = out_q[WIDTH-1];
            out_d   = {out_q[WIDTH-2:0], 1'b0};
          end
        endcase
        if (count_q == SW'(1)) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        // HOLD drains to IDLE unless a new op is taken on the same edge.
        if ((state_q == ST_HOLD) && OUT_READY) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          if (is_shift(kind_in) && (amount != '0)) begin
            out_d   = INPUT1;
            carry_d = 1'b0;
            count_d = amount;
            op_d    = kind_in;
            state_d = ST_SHIFT;
          end else begin
            out_d   = logic_y;
            carry_d = 1'b0;
            state_d = ST_HOLD;
          end
        end
      end
    endcase
  end

  always_comb begin
    IN_READY  = in_ready;
    OUT_VALID = (state_q == ST_HOLD);
    OUTPUT    = out_q;
    IS_ZERO   = (out_q == '0);
    CARRY     = carry_q;
  end

endmodule

// File: tb/tb_bitcalc_seq.sv
// Bench for bitcalc_seq: directed scenarios plus random traffic against
// a latency/result model derived from the operation definitions.
module tb_bitcalc_seq;

  localparam int unsigned W = 8;

  logic         CLK;
  logic         NRST;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] INPUT1;
  logic [W-1:0] INPUT2;
  logic [2:0]   KIND;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [W-1:0] OUTPUT;
  logic         IS_ZERO;
  logic         CARRY;

  int n_total = 0;
  int n_pass  = 0;

  bitcalc_seq #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .INPUT1    (INPUT1),
    .INPUT2    (INPUT2),
    .KIND      (KIND),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUTPUT    (OUTPUT),
    .IS_ZERO   (IS_ZERO),
    .CARRY     (CARRY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  // Reference result: whole-shift arithmetic, no per-bit stepping.
  task automatic ref_op(input logic [2:0] k, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] o, output logic c, output int unsigned lat);
    int unsigned n;
    n   = b % W;
    c   = 1'b0;
    lat = 0;
    case (k)
      3'd0: o = a;
      3'd1: o = a | b;
      3'd2: o = a & b;
      3'd3: o = a ^ b;
      3'd4: o = ~a;
      default: begin
        o = a;
        if (n != 0) begin
          lat = n;
          if (k == 3'd5) begin
            o = a << n;
            c = a[W-n];
          end else if (k == 3'd6) begin
            o = a >> n;
            c = a[n-1];
          end else begin
            o = (a << n) | (a >> (W - n));
            c = o[0];
          end
        end
      end
    endcase
  endtask

  int unsigned  m_busy;
  logic         m_valid;
  logic [W-1:0] m_out;
  logic         m_carry;

  always @(posedge CLK or negedge NRST) begin : model
    logic         rdy;
    logic [W-1:0] o;
    logic         c;
    int unsigned  lat;
    if (!NRST) begin
      m_busy  <= 0;
      m_valid <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) m_valid <= 1'b1;
    end else begin
      rdy = !m_valid || OUT_READY;
      if (m_valid && OUT_READY) m_valid <= 1'b0;
      if (rdy && IN_VALID) begin
        ref_op(KIND, INPUT1, INPUT2, o, c, lat);
        m_out   <= o;
        m_carry <= c;
        m_busy  <= lat;
        m_valid <= (lat == 0);
      end
    end
  end

  always @(negedge CLK) begin
    check("in_ready", IN_READY, (!m_valid && m_busy == 0) || (m_valid && OUT_READY));
    check("out_valid", OUT_VALID, m_valid);
    if (m_valid) begin
      check("output", OUTPUT, m_out);
      check("carry", CARRY, m_carry);
      check("is_zero", IS_ZERO, m_out == '0);
    end
  end

  // Called mid-cycle; returns at the negedge where the result is visible.
  task automatic op_check(input string nm, input logic [2:0] k, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eo, input logic ec,
                          input int unsigned ee);
    logic rdy;
    logic accepted;
    logic done;
    int unsigned edges;
    KIND = k; INPUT1 = a; INPUT2 = b; IN_VALID = 1'b1;
    accepted = 1'b0; done = 1'b0; edges = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      rdy = IN_READY;
      @(posedge CLK);
      if (accepted) edges++;
      else if (rdy) begin accepted = 1'b1; edges = 1; end
      #1;
      if (accepted) IN_VALID = 1'b0;
      @(negedge CLK);
      if (accepted && OUT_VALID) done = 1'b1;
    end
    check({nm, " done"}, done, 1'b1);
    check({nm, " edges"}, edges, ee);
    check({nm, " out"}, OUTPUT, eo);
    check({nm, " carry"}, CARRY, ec);
    check({nm, " zero"}, IS_ZERO, eo == '0);
  endtask

  initial begin
    NRST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    INPUT1 = '0; INPUT2 = '0; KIND = 3'd0;
    #12;
    check("rst out_valid", OUT_VALID, 1'b0);
    check("rst in_ready", IN_READY, 1'b1);
    check("rst output", OUTPUT, 8'h00);
    check("rst is_zero", IS_ZERO, 1'b1);
    check("rst carry", CARRY, 1'b0);
    @(negedge CLK);
    NRST = 1'b1;

    op_check("xor", 3'd3, 8'hA5, 8'hA5, 8'h00, 1'b0, 1);
    op_check("or stream", 3'd1, 8'hA0, 8'h05, 8'hA5, 1'b0, 1);
    op_check("shl", 3'd5, 8'h81, 8'h01, 8'h02, 1'b1, 2);
    op_check("rol", 3'd7, 8'h81, 8'h03, 8'h0C, 1'b0, 4);
    op_check("shr0", 3'd6, 8'h5A, 8'hF8, 8'h5A, 1'b0, 1);
    op_check("shr6", 3'd6, 8'hC0, 8'h06, 8'h03, 1'b0, 7);

    // Backpressure: drain, then hold a NOT result with OUT_READY low.
    @(posedge CLK); #1 OUT_READY = 1'b0;
    @(negedge CLK);
    op_check("not", 3'd4, 8'h0F, 8'h00, 8'hF0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      IN_VALID = 1'b1; KIND = 3'($urandom_range(0, 7)); INPUT1 = 8'($urandom);
      @(negedge CLK);
      check("bp in_ready", IN_READY, 1'b0);
      check("bp output", OUTPUT, 8'hF0);
      check("bp out_valid", OUT_VALID, 1'b1);
    end
    OUT_READY = 1'b1;
    op_check("and same-edge", 3'd2, 8'hFF, 8'h3C, 8'h3C, 1'b0, 1);

    // Reset mid-shift after the 3rd shift edge.
    KIND = 3'd6; INPUT1 = 8'hFF; INPUT2 = 8'h07; IN_VALID = 1'b1;
    @(posedge CLK); #1 IN_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #2 NRST = 1'b0;
    #1;
    check("mid rst out_valid", OUT_VALID, 1'b0);
    check("mid rst in_ready", IN_READY, 1'b1);
    check("mid rst output", OUTPUT, 8'h00);
    check("mid rst is_zero", IS_ZERO, 1'b1);
    check("mid rst carry", CARRY, 1'b0);
    repeat (3) @(negedge CLK);
    NRST = 1'b1;
    op_check("pass after rst", 3'd0, 8'h11, 8'h00, 8'h11, 1'b0, 1);

    // Random traffic; the per-cycle compare process checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge CLK); #1;
      IN_VALID  = ($urandom_range(0, 99) < 60);
      OUT_READY = ($urandom_range(0, 99) < 70);
      KIND      = 3'($urandom_range(0, 7));
      INPUT1    = 8'($urandom);
      INPUT2    = 8'($urandom);
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bitcalc_seq.md
Name: bitcalc_seq

Overview:
- Parametrised, registered successor of the 4-bit combinational bit-operation unit.
- Generalised to WIDTH bits, with NOT and shift/rotate ops added.
- Shifts run one bit per cycle, driven by a small FSM, so the block costs a fixed barrel-shifter-free area.
- Sits in the execute stage beside the adder; valid/ready handshake on both sides so the sequencer can stall or stream ops.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 2.
- SW, clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- CLK  input  1  clock, rising edge.
- NRST  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  operand/op presented.
- IN_READY  output  1  block can accept an op this cycle.
- INPUT1  input  WIDTH  operand 1 / value to shift.
- INPUT2  input  WIDTH  operand 2; for shifts, INPUT2[SW-1:0] is the amount, upper bits ignored.
- KIND  input  3  000 PASS(INPUT1), 001 OR, 010 AND, 011 XOR, 100 NOT(INPUT1), 101 SHL, 110 SHR (logical), 111 ROL.
- OUT_VALID  output  1  result valid; held until accepted.
- OUT_READY  input  1  consumer accepts result.
- OUTPUT  output  WIDTH  result register.
- IS_ZERO  output  1  all OUTPUT bits 0; combinational from the OUTPUT register.
- CARRY  output  1  last bit shifted/rotated out; 0 for ops 000-100.

Behaviour:
- Clocking/reset: one clock CLK; reset NRST is asynchronous, active-low.
- Reset values: state=IDLE, OUTPUT=0, CARRY=0, count=0, OUT_VALID=0, IN_READY=1, IS_ZERO=1.
- Reset asserted mid-operation aborts immediately. No partial result is emitted. The first op after release is accepted normally.
- States are IDLE, SHIFT, HOLD.
- Accept condition: IN_VALID & IN_READY.
- IN_READY = (state==IDLE) | (state==HOLD & OUT_READY). This gives back-to-back throughput of 1 op/cycle for logic ops.
- On accept with KIND 000-100, or a shift with amount n==0:
  - OUTPUT <= op result (n==0 gives INPUT1); CARRY <= 0.
  - state -> HOLD; latency 1 edge.
- On accept with a shift and n>0:
  - OUTPUT <= INPUT1, count <= n, latched op <= KIND; state -> SHIFT.
- SHIFT, each edge performs one step and count decrements:
  - SHL: CARRY <= OUTPUT[WIDTH-1], OUTPUT <= {OUTPUT[WIDTH-2:0],0}.
  - SHR: CARRY <= OUTPUT[0], OUTPUT <= {0,OUTPUT[WIDTH-1:1]}.
  - ROL: CARRY <= OUTPUT[WIDTH-1], OUTPUT <= {OUTPUT[WIDTH-2:0],OUTPUT[WIDTH-1]}.
  - When count==1 at the edge, state -> HOLD. Total latency is n+1 edges after the accept edge inclusive; max n = WIDTH-1.
- HOLD: OUT_VALID=1; OUTPUT and CARRY are stable until OUT_READY.
  - OUT_READY & !IN_VALID -> IDLE.
  - OUT_READY & IN_VALID -> new op accepted on the same edge, handled as an accept from IDLE.
- During SHIFT:
  - IN_READY=0, OUT_VALID=0; IN_VALID and INPUT* are ignored.
  - OUTPUT shows the intermediate value and is meaningful only when OUT_VALID=1.
  - Operand changes after accept have no effect; everything used is latched.
- OUT_READY is ignored when OUT_VALID=0.

Decomposition:
- Package bitcalc_pkg: KIND encodings (KIND_PASS..KIND_ROL), state encoding (ST_IDLE, ST_SHIFT, ST_HOLD), and helper for SW.
- Sub-module bitcalc_logic: combinational WIDTH-parametric PASS/OR/AND/XOR/NOT unit used on the accept path.
- The top module holds the FSM, counter and shift datapath.

Test Plan (WIDTH=8):
- Reset: NRST=0 at arbitrary time -> OUT_VALID=0, IN_READY=1, OUTPUT=0x00, IS_ZERO=1, CARRY=0.
- XOR 0xA5,0xA5 with OUT_READY=1 -> OUT_VALID after 1 edge, OUTPUT=0x00, IS_ZERO=1; then OR 0xA0,0x05 streamed next cycle -> 0xA5, IS_ZERO=0.
- Shifts, each checked against its edge count:
  - SHL 0x81 by 1 -> OUT_VALID after 2 edges, OUTPUT=0x02, CARRY=1.
  - ROL 0x81 by 3 -> after 4 edges, OUTPUT=0x0C, CARRY=0.
- SHR 0x5A by 0 (INPUT2=0xF8, upper bits ignored) -> 1 edge, OUTPUT=0x5A, CARRY=0.
- Backpressure:
  - NOT 0x0F, OUT_READY=0 for 5 cycles -> OUTPUT=0xF0 stable, IN_READY=0, extra IN_VALID pulses not accepted.
  - Then OUT_READY=1 with IN_VALID=1 (AND 0xFF,0x3C) -> same-edge accept, next result 0x3C.
- Reset mid-shift: SHR 0xFF by 7, NRST low after the 3rd shift edge -> immediate IDLE/reset values, no OUT_VALID. After release, PASS 0x11 -> 0x11 in 1 edge.
